// File: rtl/puck_mover_pkg.sv
// Shared definitions for the puck renderer: state encoding, screen geometry,
// colours and the per-axis bounce decision.
package puck_mover_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    MOVE  = 2'd2,
    DRAW  = 2'd3
  } state_e;

  localparam int X_MAX = 160;
  localparam int Y_MAX = 120;

  localparam logic [2:0] BG_COLOUR   = 3'b000;
  localparam logic [2:0] PUCK_COLOUR = 3'b111;

  typedef struct packed {
    logic neg;  // direction after this step: 1 = moving towards 0
    logic hit;  // a wall reversed the direction on this step
  } bounce_t;

  // A puck sitting on the wall it is heading into reverses before stepping.
  function automatic bounce_t bounce(input logic [7:0] pos, input logic neg,
                                     input logic [7:0] hi);
    bounce_t r;
    r.neg = neg;
    r.hit = 1'b0;
    if (!neg && pos == hi) begin
      r.neg = 1'b1;
      r.hit = 1'b1;
    end else if (neg && pos == 8'd0) begin
      r.neg = 1'b0;
      r.hit = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/puck_mover_if.sv
// Frame control in, VGA adapter pixel stream and puck status out.
interface puck_mover_if;
  logic       enable;
  logic       frame_tick;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic [7:0] puck_x;
  logic [6:0] puck_y;
  logic       busy;
  logic       wall_hit;

  modport slave (
    input  enable, frame_tick,
    output x_out, y_out, colour, plot, puck_x, puck_y, busy, wall_hit
  );

  modport master (
    output enable, frame_tick,
    input  x_out, y_out, colour, plot, puck_x, puck_y, busy, wall_hit
  );
endinterface

// File: rtl/puck_pixel_counter.sv
// Raster pixel counter over a square sprite; exposes the value it will hold
// next cycle so callers can register pixel coordinates without a lag.
module puck_pixel_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt_next,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  assign cnt_next = cnt_d;
  assign last     = &cnt_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (resetn) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/puck_mover.sv
// Per-frame erase / move / draw sequencer for the puck, streaming pixels to
// the VGA adapter with all outputs registered.
module puck_mover
  import puck_mover_pkg::*;
#(
  parameter int PUCK_SIZE = 4,
  parameter int X_INIT    = 78,
  parameter int Y_INIT    = 58
) (
  input logic          clock,
  input logic          resetn,
  puck_mover_if.slave  bus
);

  localparam int K  = $clog2(PUCK_SIZE);
  localparam int CW = 2 * K;
  localparam logic [7:0] X_HI = 8'(X_MAX - PUCK_SIZE);
  localparam logic [7:0] Y_HI = 8'(Y_MAX - PUCK_SIZE);

  state_e     state_q, state_d;
  logic [7:0] puck_x_q, puck_x_d;
  logic [6:0] puck_y_q, puck_y_d;
  logic       dx_neg_q, dx_neg_d;
  logic       dy_neg_q, dy_neg_d;
  logic [7:0] x_out_q, x_out_d;
  logic [6:0] y_out_q, y_out_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       wall_hit_q, wall_hit_d;

  logic          cnt_clr, cnt_en, cnt_last, emit;
  logic [CW-1:0] cnt_next;
  bounce_t       bx, by;

  puck_pixel_counter #(.W(CW)) u_cnt (
    .clock    (clock),
    .resetn   (resetn),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .cnt_next (cnt_next),
    .last     (cnt_last)
  );

  always_comb begin
    bx = bounce(puck_x_q, dx_neg_q, X_HI);
    by = bounce({1'b0, puck_y_q}, dy_neg_q, Y_HI);
  end

  always_comb begin
    state_d    = state_q;
    puck_x_d   = puck_x_q;
    puck_y_d   = puck_y_q;
    dx_neg_d   = dx_neg_q;
    dy_neg_d   = dy_neg_q;
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    colour_d   = colour_q;
    busy_d     = busy_q;
    plot_d     = 1'b0;
    wall_hit_d = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    emit       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.frame_tick && bus.enable) begin
          state_d  = ERASE;
          cnt_clr  = 1'b1;
          busy_d   = 1'b1;
          colour_d = BG_COLOUR;
          emit     = 1'b1;
        end
      end
      ERASE: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d    = MOVE;
          wall_hit_d = bx.hit | by.hit;
        end else begin
          emit = 1'b1;
        end
      end
      MOVE: begin
        dx_neg_d = bx.neg;
        dy_neg_d = by.neg;
        puck_x_d = bx.neg ? puck_x_q - 8'd1 : puck_x_q + 8'd1;
        puck_y_d = by.neg ? puck_y_q - 7'd1 : puck_y_q + 7'd1;
        state_d  = DRAW;
        cnt_clr  = 1'b1;
        colour_d = PUCK_COLOUR;
        emit     = 1'b1;
      end
      DRAW: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          emit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Coordinates come from the counter's next value and the position the
    // puck will hold, so the first pixel of each pass is not delayed a cycle.
    if (emit) begin
      plot_d  = 1'b1;
      x_out_d = puck_x_d + 8'(cnt_next[K-1:0]);
      y_out_d = puck_y_d + 7'(cnt_next[CW-1:K]);
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q    <= IDLE;
      puck_x_q   <= 8'(X_INIT);
      puck_y_q   <= 7'(Y_INIT);
      dx_neg_q   <= 1'b0;
      dy_neg_q   <= 1'b0;
      x_out_q    <= 8'd0;
      y_out_q    <= 7'd0;
      colour_q   <= BG_COLOUR;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      wall_hit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      puck_x_q   <= puck_x_d;
      puck_y_q   <= puck_y_d;
      dx_neg_q   <= dx_neg_d;
      dy_neg_q   <= dy_neg_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      busy_q     <= busy_d;
      wall_hit_q <= wall_hit_d;
    end
  end

  assign bus.x_out    = x_out_q;
  assign bus.y_out    = y_out_q;
  assign bus.colour   = colour_q;
  assign bus.plot     = plot_q;
  assign bus.puck_x   = puck_x_q;
  assign bus.puck_y   = puck_y_q;
  assign bus.busy     = busy_q;
  assign bus.wall_hit = wall_hit_q;

endmodule

// File: doc/puck_mover.md
# puck_mover

Frame-rate puck motion and render stage. Consumes the one-cycle frame tick from the frame counter and, on each accepted tick, erases the puck at its current position, advances it one pixel per axis with wall bouncing, and redraws it. Emits a pixel stream (x, y, colour, plot) straight into the VGA adapter write port, and publishes the puck position for downstream collision and scoring logic.

## Interface
- X_MAX, 160, screen width in pixels
- Y_MAX, 120, screen height in pixels
- PUCK_SIZE, 4, puck edge length in pixels; power of two, at least 2
- X_INIT, 78, reset x of puck top-left corner
- Y_INIT, 58, reset y of puck top-left corner
- BG_COLOUR, 3'b000, erase colour
- PUCK_COLOUR, 3'b111, draw colour

- clock  in  1  system clock
- resetn  in  1  synchronous reset, active-high despite the name
- enable  in  1  gates acceptance of frame ticks
- frame_tick  in  1  one-cycle pulse per frame
- x_out  out  8  pixel x to VGA adapter
- y_out  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour to VGA adapter
- plot  out  1  pixel write strobe
- puck_x  out  8  current puck top-left x
- puck_y  out  7  current puck top-left y
- busy  out  1  high while an erase/move/draw sequence runs
- wall_hit  out  1  one-cycle pulse when a bounce occurs

## Operation
- Reset values: plot 0, busy 0, wall_hit 0, x_out 0, y_out 0, colour BG_COLOUR, puck_x X_INIT, puck_y Y_INIT, dx +1, dy +1, state IDLE.
- States: IDLE, ERASE, MOVE, DRAW.
  - IDLE: when frame_tick is high and enable is high, go to ERASE and clear the pixel counter.
  - ERASE: emit PUCK_SIZE² pixels at the current position in BG_COLOUR. Go to MOVE after the last pixel.
  - MOVE: update position and direction (one cycle, plot 0). Go to DRAW and clear the pixel counter.
  - DRAW: emit PUCK_SIZE² pixels at the new position in PUCK_COLOUR. Go to IDLE after the last pixel.
- Pixel order is raster order within the square:
  - x_out = puck_x + cnt[k-1:0]
  - y_out = puck_y + cnt[2k-1:k]
  - k = log2(PUCK_SIZE)
- x axis step:
  - If dx = +1 and puck_x = X_MAX-PUCK_SIZE: dx becomes -1, puck_x decrements.
  - If dx = -1 and puck_x = 0: dx becomes +1, puck_x increments.
  - Otherwise puck_x = puck_x + dx.
- y axis step: same rule using Y_MAX, dy and puck_y.
- The position never leaves the range [0, MAX-PUCK_SIZE]. Arithmetic is unsigned at 8 and 7 bits; no wrap-around is possible.
- wall_hit pulses exactly once in the MOVE cycle if either axis bounced. A corner bounce still gives a single pulse.
- frame_tick while busy: dropped, with no queuing.
- frame_tick with enable low: ignored. A sequence already in progress always completes regardless of enable.
- resetn mid-sequence: immediate return to reset values. Stale pixels on screen are not erased.

## Timing
- All outputs are registered.
- Tick sampled in IDLE at cycle 0:
  - ERASE pixels: plot high cycles 1..16
  - MOVE: cycle 17, plot 0, wall_hit valid
  - DRAW pixels: cycles 18..33
  - IDLE again: cycle 34
- Figures above are for PUCK_SIZE 4. In general the sequence takes 2·PUCK_SIZE²+2 cycles.
- busy is high in cycles 1..33. A tick is accepted again from cycle 34.
- puck_x and puck_y show the new position from cycle 18.
- The frame period must exceed the sequence length. The minimum frame counter period of 176 cycles satisfies this.

## Structure
- Shared package holds:
  - the state encoding (IDLE, ERASE, MOVE, DRAW)
  - the colour constants
  - the X_MAX and Y_MAX screen dimensions
- Sub-module puck_pixel_counter: a 2k-bit counter with clear and enable inputs and a last flag. It is reused by the paddle renderer.

## Test plan
- Reset, then one tick with enable 1:
  - 16 erase pixels at (78..81, 58..61) in colour 000
  - then 16 draw pixels at (79..82, 59..62) in colour 111
  - puck_x=79, puck_y=59
- Preload the right edge (X_INIT=156, dx +1), then one tick:
  - puck_x=155, dx=-1
  - wall_hit pulses one cycle at cycle 17
- Preload the corner (X_INIT=156, Y_INIT=116), then one tick:
  - position (155,115), both directions flipped
  - exactly one wall_hit pulse
- Ticks at cycles 0 and 10:
  - second tick dropped
  - exactly 32 plot cycles; position advances by 1 only
- enable 0 with 3 ticks: no plot, position unchanged. A tick arriving with enable 1 at cycle 5 followed by enable 0 still completes all 34 cycles.
- Assert resetn at cycle 20 of a sequence: next cycle plot=0, busy=0, position (78,58), dx=dy=+1.
